// File: rtl/clk_ratio_meter_pkg.sv
// Shared types and defaults for the slow-clock ratio meter.
// FSM encoding and default counter width.
package clk_ratio_meter_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TRACK   = 2'd2,
    LOCKED  = 2'd3
  } state_e;

endpackage

// File: rtl/clk_ratio_meter_sync_edge_detect.sv
// Synchronizer chain for a slow clock sampled as data,
// plus a previous-sample flop for rising-edge detection.
module sync_edge_detect
  import clk_ratio_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_sync = sync_q[SYNC_STAGES-1];
  assign o_rise = o_sync & ~prev_q;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures the period of a slow clock in i_clk cycles, with lock/timeout.
// Define CLK_RATIO_METER_HIGH_EN to add the o_high_time output.
module clk_ratio_meter
  import clk_ratio_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int PERIOD_TOL  = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_meas_clk,
  output logic             o_edge,
  output logic [CNT_W-1:0] o_period,
  output logic             o_period_valid,
  output logic             o_locked,
`ifdef CLK_RATIO_METER_HIGH_EN
  output logic [CNT_W-1:0] o_high_time,
`endif
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [MC_W-1:0] LOCK_N = MC_W'(LOCK_COUNT);
  localparam logic [CNT_W:0] TOL = (CNT_W+1)'(PERIOD_TOL);

  logic sync, rise;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_meas_clk),
    .o_sync (sync),
    .o_rise (rise)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ref_q, ref_d;
  logic [MC_W-1:0]  mc_q, mc_d, mc_inc;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             edge_q, locked_q, timeout_q;
  logic             sat, match;
  logic [CNT_W:0]   diff;

  always_comb begin
    sat = (cnt_q == MAX);
    if ({1'b0, cnt_q} >= {1'b0, ref_q})
      diff = {1'b0, cnt_q} - {1'b0, ref_q};
    else
      diff = {1'b0, ref_q} - {1'b0, cnt_q};
    match  = (diff <= TOL);
    mc_inc = mc_q + 1'b1;

    state_d  = state_q;
    ref_d    = ref_q;
    mc_d     = mc_q;
    period_d = period_q;
    valid_d  = 1'b0;
    cnt_d    = rise ? CNT_W'(1) : (sat ? cnt_q : cnt_q + 1'b1);

    if (rise && sat) begin
      // out-of-range period: restart with this edge as reference
      state_d = MEASURE;
    end else if (rise) begin
      unique case (state_q)
        IDLE: state_d = MEASURE;
        MEASURE: begin
          valid_d  = 1'b1;
          period_d = cnt_q;
          ref_d    = cnt_q;
          mc_d     = MC_W'(1);
          state_d  = (LOCK_COUNT <= 1) ? LOCKED : TRACK;
        end
        TRACK: begin
          valid_d  = 1'b1;
          period_d = cnt_q;
          if (match) begin
            mc_d = mc_inc;
            if (mc_inc >= LOCK_N) state_d = LOCKED;
          end else begin
            ref_d = cnt_q;
            mc_d  = MC_W'(1);
          end
        end
        LOCKED: begin
          valid_d  = 1'b1;
          period_d = cnt_q;
          if (!match) begin
            ref_d   = cnt_q;
            mc_d    = MC_W'(1);
            state_d = (LOCK_COUNT <= 1) ? LOCKED : TRACK;
          end
        end
      endcase
    end else if (sat) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ref_q     <= '0;
      mc_q      <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      edge_q    <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_q     <= ref_d;
      mc_q      <= mc_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      edge_q    <= rise;
      locked_q  <= (state_d == LOCKED);
      timeout_q <= sat;
    end
  end

`ifdef CLK_RATIO_METER_HIGH_EN
  logic [CNT_W-1:0] hi_q, hi_out_q, hi_sum;

  assign hi_sum = (hi_q == MAX) ? MAX : hi_q + CNT_W'(sync);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi_q     <= '0;
      hi_out_q <= '0;
    end else begin
      hi_q <= rise ? '0 : hi_sum;
      if (valid_d) hi_out_q <= hi_sum;
    end
  end

  assign o_high_time = hi_out_q;
`else
  logic sync_unused;
  assign sync_unused = sync;
`endif

  assign o_edge         = edge_q;
  assign o_period       = period_q;
  assign o_period_valid = valid_q;
  assign o_locked       = locked_q;
  assign o_timeout      = timeout_q;

endmodule
